// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 8-bit memory bus between the fetch and data requesters.
// Arbitrates on a request, splits word accesses into two little-endian byte cycles,
// and returns a single one-cycle ack per request.
module mem_arbiter #(
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_fetch_req,
    input  logic [15:0] I_fetch_addr,
    output logic        O_fetch_ack,
    output logic [15:0] O_fetch_data,
    input  logic        I_data_req,
    input  logic [1:0]  I_data_mode,
    input  logic [1:0]  I_data_size,
    input  logic [15:0] I_data_addr,
    input  logic [15:0] I_data_wdata,
    output logic        O_data_ack,
    output logic [15:0] O_data_rdata,
    output logic        O_bus_valid,
    output logic        O_bus_we,
    output logic [15:0] O_bus_addr,
    output logic [7:0]  O_bus_wdata,
    input  logic [7:0]  I_bus_rdata,
    input  logic        I_bus_ready,
    output logic        O_busy
);

    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {StIdle, StByte0, StByte1, StDone} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;            // 1 = data requester owns the access
    logic        last_grant_q, last_grant_d;  // 1 = data was granted last
    logic        word_q, word_d;
    logic [7:0]  wdata_hi_q, wdata_hi_d;
    logic [7:0]  rd_lo_q, rd_lo_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic        fetch_ack_q, fetch_ack_d;
    logic [15:0] fetch_data_q, fetch_data_d;
    logic        data_ack_q, data_ack_d;
    logic [15:0] data_rdata_q, data_rdata_d;
    logic        busy_q, busy_d;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        logic        win_data;
        logic        finish;
        logic [15:0] result;
        logic [1:0]  mode;

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        wdata_hi_d   = wdata_hi_q;
        rd_lo_d      = rd_lo_q;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        fetch_ack_d  = 1'b0;
        fetch_data_d = fetch_data_q;
        data_ack_d   = 1'b0;
        data_rdata_d = data_rdata_q;
        win_data     = 1'b0;
        finish       = 1'b0;
        result       = 16'h0000;
        mode         = MEM_READ;

        unique case (state_q)
            StIdle: begin
                if (I_fetch_req || I_data_req) begin
                    // On a tie, round-robin picks whichever requester was not granted last.
                    if (I_fetch_req && I_data_req) begin
                        win_data = (DATA_PRIORITY != 0) ? 1'b1 : !last_grant_q;
                    end else begin
                        win_data = I_data_req;
                    end
                    grant_d      = win_data;
                    last_grant_d = win_data;
                    mode         = win_data ? I_data_mode : MEM_READ;
                    if (mode != MEM_READ && mode != MEM_WRITE) begin
                        // NOP (and the unused encoding) completes without a bus cycle.
                        state_d    = StDone;
                        data_ack_d = 1'b1;
                    end else begin
                        state_d     = StByte0;
                        bus_valid_d = 1'b1;
                        bus_we_d    = (mode == MEM_WRITE);
                        bus_addr_d  = win_data ? I_data_addr : I_fetch_addr;
                        bus_wdata_d = win_data ? I_data_wdata[7:0] : 8'h00;
                        wdata_hi_d  = win_data ? I_data_wdata[15:8] : 8'h00;
                        word_d      = win_data ? (I_data_size == SIZE_WORD) : 1'b1;
                    end
                end
            end
            StByte0: begin
                if (I_bus_ready) begin
                    rd_lo_d = I_bus_rdata;
                    if (word_q) begin
                        state_d     = StByte1;
                        bus_addr_d  = bus_addr_q + 16'd1;
                        bus_wdata_d = wdata_hi_q;
                    end else begin
                        finish = 1'b1;
                        result = {8'h00, I_bus_rdata};
                    end
                end
            end
            StByte1: begin
                if (I_bus_ready) begin
                    finish = 1'b1;
                    result = {I_bus_rdata, rd_lo_q};
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            state_d     = StDone;
            bus_valid_d = 1'b0;
            if (grant_q) begin
                data_ack_d = 1'b1;
                if (!bus_we_q) begin
                    data_rdata_d = result;
                end
            end else begin
                fetch_ack_d  = 1'b1;
                fetch_data_d = result;
            end
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            word_q       <= 1'b0;
            wdata_hi_q   <= 8'h00;
            rd_lo_q      <= 8'h00;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 16'h0000;
            bus_wdata_q  <= 8'h00;
            fetch_ack_q  <= 1'b0;
            fetch_data_q <= 16'h0000;
            data_ack_q   <= 1'b0;
            data_rdata_q <= 16'h0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            wdata_hi_q   <= wdata_hi_d;
            rd_lo_q      <= rd_lo_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            fetch_ack_q  <= fetch_ack_d;
            fetch_data_q <= fetch_data_d;
            data_ack_q   <= data_ack_d;
            data_rdata_q <= data_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign O_fetch_ack  = fetch_ack_q;
    assign O_fetch_data = fetch_data_q;
    assign O_data_ack   = data_ack_q;
    assign O_data_rdata = data_rdata_q;
    assign O_bus_valid  = bus_valid_q;
    assign O_bus_we     = bus_we_q;
    assign O_bus_addr   = bus_addr_q;
    assign O_bus_wdata  = bus_wdata_q;
    assign O_busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: data-priority instance with a byte memory model,
// plus a round-robin instance with an always-ready bus.
module tb_mem_arbiter;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [15:0] f_data;
    logic        d_req;
    logic [1:0]  d_mode;
    logic [1:0]  d_size;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        b_valid;
    logic        b_we;
    logic [15:0] b_addr;
    logic [7:0]  b_wdata;
    logic [7:0]  b_rdata;
    logic        b_ready;
    logic        busy;

    logic        r_f_req;
    logic        r_f_ack;
    logic [15:0] r_f_data;
    logic        r_d_req;
    logic        r_d_ack;
    logic [15:0] r_d_rdata;
    logic        r_valid;
    logic        r_we;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_busy;
    logic [15:0] r_f_addr  = 16'h0200;
    logic [15:0] r_d_addr  = 16'h0300;
    logic [15:0] r_d_wdata = 16'h0000;
    logic [1:0]  r_d_mode  = 2'd1;
    logic [1:0]  r_d_size  = 2'd0;
    logic [7:0]  r_rdata   = 8'h5A;
    logic        r_ready   = 1'b1;

    logic [7:0]  mem [0:65535];
    int          wait_cfg;
    int          wcnt;
    int          d_ack_cnt;
    logic [15:0] wlog_addr [$];
    logic [7:0]  wlog_data [$];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_PRIORITY(1)) u_dut (
        .I_clk(clk), .I_reset_n(rst_n),
        .I_fetch_req(f_req), .I_fetch_addr(f_addr), .O_fetch_ack(f_ack), .O_fetch_data(f_data),
        .I_data_req(d_req), .I_data_mode(d_mode), .I_data_size(d_size), .I_data_addr(d_addr),
        .I_data_wdata(d_wdata), .O_data_ack(d_ack), .O_data_rdata(d_rdata),
        .O_bus_valid(b_valid), .O_bus_we(b_we), .O_bus_addr(b_addr), .O_bus_wdata(b_wdata),
        .I_bus_rdata(b_rdata), .I_bus_ready(b_ready), .O_busy(busy)
    );

    mem_arbiter #(.DATA_PRIORITY(0)) u_rr (
        .I_clk(clk), .I_reset_n(rst_n),
        .I_fetch_req(r_f_req), .I_fetch_addr(r_f_addr), .O_fetch_ack(r_f_ack),
        .O_fetch_data(r_f_data),
        .I_data_req(r_d_req), .I_data_mode(r_d_mode), .I_data_size(r_d_size),
        .I_data_addr(r_d_addr), .I_data_wdata(r_d_wdata), .O_data_ack(r_d_ack),
        .O_data_rdata(r_d_rdata),
        .O_bus_valid(r_valid), .O_bus_we(r_we), .O_bus_addr(r_addr), .O_bus_wdata(r_wdata),
        .I_bus_rdata(r_rdata), .I_bus_ready(r_ready), .O_busy(r_busy)
    );

    // Memory model: read-only array, completed writes go to a log; ready after wait_cfg waits.
    assign b_ready = b_valid && (wcnt >= wait_cfg);
    assign b_rdata = mem[b_addr];

    always @(posedge clk) begin
        if (!b_valid || b_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (b_valid && b_ready && b_we) begin
            wlog_addr.push_back(b_addr);
            wlog_data.push_back(b_wdata);
        end
        if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input bit is_data, input int budget,
                            output int cyc);
        cyc = 0;
        while (1) begin
            tick();
            cyc++;
            if ((is_data ? d_ack : f_ack) === 1'b1) break;
            if (cyc >= budget) begin
                n_cmp++;
                n_mis++;
                $error("FAIL %s: no ack observed within %0d cycles, ack required", tag, budget);
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int ack_before;
        int nseq;
        int seq [3];

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        mem[16'h0020] = 8'h80;
        mem[16'h0030] = 8'h11;
        mem[16'h0031] = 8'h22;
        mem[16'h0040] = 8'h55;
        mem[16'h0041] = 8'h66;
        wait_cfg = 0;
        wcnt = 0;
        d_ack_cnt = 0;
        rst_n = 1'b0;
        f_req = 1'b0; f_addr = 16'h0000;
        d_req = 1'b0; d_mode = MEM_NOP; d_size = 2'd0; d_addr = 16'h0000; d_wdata = 16'h0000;
        r_f_req = 1'b0; r_d_req = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_flags", {27'd0, f_ack, d_ack, b_valid, b_we, busy}, 32'd0);
        check("rst_bus_addr", {16'd0, b_addr}, 32'd0);
        check("rst_rdata", {f_data, d_rdata}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_no_req", {30'd0, b_valid, busy}, 32'd0);

        // Fetch word at 0x0100, zero wait states
        f_addr = 16'h0100;
        f_req = 1'b1;
        tick();
        check("fetch_b0", {14'd0, b_valid, b_we, b_addr}, {14'd0, 1'b1, 1'b0, 16'h0100});
        check("fetch_busy", {31'd0, busy}, 32'd1);
        tick();
        check("fetch_b1", {15'd0, b_valid, b_addr}, {15'd0, 1'b1, 16'h0101});
        tick();
        check("fetch_ack_n3", {15'd0, f_ack, f_data}, {15'd0, 1'b1, 16'h1234});
        check("fetch_valid_drop", {31'd0, b_valid}, 32'd0);
        f_req = 1'b0;
        tick();
        check("fetch_after", {30'd0, f_ack, busy}, 32'd0);

        // Simultaneous requests: data priority
        d_mode = MEM_READ; d_size = 2'd2; d_addr = 16'h0030;
        f_req = 1'b1; d_req = 1'b1;
        cyc = 0;
        while (f_ack !== 1'b1 && d_ack !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("prio_first_ack", {30'd0, f_ack, d_ack}, {30'd0, 1'b0, 1'b1});
        check("prio_data_word", {16'd0, d_rdata}, {16'd0, 16'h2211});
        d_req = 1'b0;
        wait_ack("prio_fetch_second", 1'b0, 20, cyc);
        check("prio_fetch_lat", cyc, 4);
        check("prio_fetch_data", {16'd0, f_data}, {16'd0, 16'h1234});
        f_req = 1'b0;
        tick();

        // Byte read, zero-extended
        d_mode = MEM_READ; d_size = 2'd0; d_addr = 16'h0020;
        d_req = 1'b1;
        wait_ack("byte_read", 1'b1, 20, cyc);
        check("byte_read_lat", cyc, 2);
        check("byte_read_data", {16'd0, d_rdata}, {16'd0, 16'h0080});
        d_req = 1'b0;
        tick();

        // NOP and unused mode: ack next cycle, no bus cycle
        d_mode = MEM_NOP;
        d_req = 1'b1;
        tick();
        check("nop_ack", {30'd0, d_ack, b_valid}, {30'd0, 1'b1, 1'b0});
        d_req = 1'b0;
        tick();
        check("nop_done", {30'd0, d_ack, busy}, 32'd0);
        d_mode = 2'd3;
        d_req = 1'b1;
        tick();
        check("mode3_ack", {30'd0, d_ack, b_valid}, {30'd0, 1'b1, 1'b0});
        d_req = 1'b0;
        tick();

        // Word write across 0xFFFF wrap with two wait states per byte
        wait_cfg = 2;
        ack_before = d_ack_cnt;
        d_mode = MEM_WRITE; d_size = 2'd2; d_addr = 16'hFFFF; d_wdata = 16'hBEEF;
        d_req = 1'b1;
        tick();
        check("wr_b0", {7'd0, b_valid, b_we, b_addr, b_wdata}, {7'd0, 1'b1, 1'b1, 16'hFFFF, 8'hEF});
        tick();
        check("wr_hold", {15'd0, b_valid, b_addr}, {15'd0, 1'b1, 16'hFFFF});
        wait_ack("wr_ack", 1'b1, 30, cyc);
        check("wr_ack_lat", cyc, 5);
        d_req = 1'b0;
        tick();
        tick();
        check("wr_single_ack", d_ack_cnt - ack_before, 1);
        check("wr_log_size", wlog_addr.size(), 2);
        if (wlog_addr.size() >= 2) begin
            check("wr_byte0", {8'd0, wlog_addr[0], wlog_data[0]}, {8'd0, 16'hFFFF, 8'hEF});
            check("wr_byte1", {8'd0, wlog_addr[1], wlog_data[1]}, {8'd0, 16'h0000, 8'hBE});
        end
        check("wr_rdata_kept", {16'd0, d_rdata}, {16'd0, 16'h0080});
        wait_cfg = 0;

        // Reset during second byte of a word read
        ack_before = d_ack_cnt;
        d_mode = MEM_READ; d_size = 2'd2; d_addr = 16'h0040;
        d_req = 1'b1;
        tick();
        tick();
        check("rst_mid_b1", {15'd0, b_valid, b_addr}, {15'd0, 1'b1, 16'h0041});
        rst_n = 1'b0;
        tick();
        check("rst_mid_out", {29'd0, b_valid, busy, d_ack}, 32'd0);
        rst_n = 1'b1;
        d_req = 1'b0;
        tick();
        tick();
        check("rst_mid_no_ack", d_ack_cnt - ack_before, 0);
        check("rst_mid_idle", {31'd0, busy}, 32'd0);

        // Round-robin instance: data alone first, then both held high continuously
        r_d_req = 1'b1;
        cyc = 0;
        while (r_d_ack !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("rr_data_alone", {31'd0, r_d_ack}, 32'd1);
        r_d_req = 1'b0;
        tick();
        r_f_req = 1'b1;
        r_d_req = 1'b1;
        nseq = 0;
        cyc = 0;
        while (nseq < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (r_f_ack === 1'b1) begin
                seq[nseq] = 0;
                nseq++;
            end else if (r_d_ack === 1'b1) begin
                seq[nseq] = 1;
                nseq++;
            end
        end
        check("rr_count", nseq, 3);
        if (nseq == 3) begin
            check("rr_grant0_fetch", seq[0], 0);
            check("rr_grant1_data", seq[1], 1);
            check("rr_grant2_fetch", seq[2], 0);
        end
        r_f_req = 1'b0;
        r_d_req = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
